// File: rtl/nvmain_cmd_issuer.sv
// Initiator for the NVMain command interface: lowercase query, wait verdict, uppercase issue.
// Latency: accept->query strobe 1 cycle, verdict->issue strobe 1 cycle, issue->done 1 cycle.
// Backpressure: req_ready only in IDLE; one request in flight, rejects retried after a gap.
//
// Ports:
//   clk, reset           clock, asynchronous active-high reset
//   req_*                request handshake and fields (type, a1..a4)
//   command_enable,arg*  one-cycle command strobe and its 5-field argument bus
//   rsp_valid/issuable   harness verdict for the outstanding query
//   done, err, err_code  completion / abandonment pulses; err_code holds last value
// Optional: define NVMAIN_CMD_TRACE_EN to print every command sent and every error.
module nvmain_cmd_issuer #(
  parameter int RETRY_GAP   = 4,
  parameter int MAX_RETRY   = 8,
  parameter int RSP_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_type,
  input  logic [31:0] req_a1,
  input  logic [31:0] req_a2,
  input  logic [31:0] req_a3,
  input  logic [7:0]  req_a4,
  output logic        command_enable,
  output logic [7:0]  arg0,
  output logic [31:0] arg1,
  output logic [31:0] arg2,
  output logic [31:0] arg3,
  output logic [7:0]  arg4,
  input  logic        rsp_valid,
  input  logic        rsp_issuable,
  output logic        done,
  output logic        err,
  output logic [1:0]  err_code
);

  typedef enum logic [2:0] {
    S_IDLE, S_QUERY, S_WAIT_RSP, S_BACKOFF, S_ISSUE, S_DONE, S_ERR
  } state_t;

  localparam logic [15:0] TIMER_LAST  = 16'(RSP_TIMEOUT - 1);
  localparam logic [15:0] GAP_LAST    = 16'(RETRY_GAP - 1);
  localparam logic [7:0]  RETRY_LIMIT = 8'(MAX_RETRY);

  state_t      r_state, w_state_nxt;
  logic [15:0] r_timer, w_timer_nxt;
  logic [7:0]  r_retry, w_retry_nxt;
  logic [1:0]  r_err_code, w_err_code_nxt;
  logic [1:0]  r_type;
  logic [7:0]  r_arg0;
  logic [31:0] r_arg1, r_arg2, r_arg3;
  logic [7:0]  r_arg4;
  logic        w_accept;
  logic        w_to_issue;

  // Every 2-bit type maps to a legal lowercase opcode.
  function automatic logic [7:0] f_lower(input logic [1:0] t);
    case (t)
      2'd0:    f_lower = 8'h72;  // 'r'
      2'd1:    f_lower = 8'h77;  // 'w'
      2'd2:    f_lower = 8'h6C;  // 'l'
      default: f_lower = 8'h63;  // 'c'
    endcase
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_timer_nxt    = r_timer;
    w_retry_nxt    = r_retry;
    w_err_code_nxt = r_err_code;
    w_accept       = 1'b0;
    w_to_issue     = 1'b0;
    req_ready      = 1'b0;
    command_enable = 1'b0;
    done           = 1'b0;
    err            = 1'b0;
    case (r_state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = S_QUERY;
        end
      end
      S_QUERY: begin
        command_enable = 1'b1;
        w_timer_nxt    = 16'd0;
        w_state_nxt    = S_WAIT_RSP;
      end
      S_WAIT_RSP: begin
        w_timer_nxt = r_timer + 16'd1;
        // A verdict on the final timeout cycle takes priority over the timeout.
        if (rsp_valid) begin
          if (rsp_issuable) begin
            w_to_issue  = 1'b1;
            w_state_nxt = S_ISSUE;
          end else begin
            w_retry_nxt = r_retry + 8'd1;
            if (r_retry + 8'd1 == RETRY_LIMIT) begin
              w_err_code_nxt = 2'd1;
              w_state_nxt    = S_ERR;
            end else begin
              w_timer_nxt = 16'd0;
              w_state_nxt = S_BACKOFF;
            end
          end
        end else if (r_timer == TIMER_LAST) begin
          w_err_code_nxt = 2'd2;
          w_state_nxt    = S_ERR;
        end
      end
      S_BACKOFF: begin
        if (r_timer == GAP_LAST) begin
          w_state_nxt = S_QUERY;
        end else begin
          w_timer_nxt = r_timer + 16'd1;
        end
      end
      S_ISSUE: begin
        command_enable = 1'b1;
        w_state_nxt    = S_DONE;
      end
      S_DONE: begin
        done        = 1'b1;
        w_retry_nxt = 8'd0;
        w_state_nxt = S_IDLE;
      end
      S_ERR: begin
        err         = 1'b1;
        w_retry_nxt = 8'd0;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Argument registers double as the request buffer: they load on the accept
  // edge, which is also the edge on which the query strobe rises.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_timer    <= 16'd0;
      r_retry    <= 8'd0;
      r_err_code <= 2'd0;
      r_type     <= 2'd0;
      r_arg0     <= 8'd0;
      r_arg1     <= 32'd0;
      r_arg2     <= 32'd0;
      r_arg3     <= 32'd0;
      r_arg4     <= 8'd0;
    end else begin
      r_timer    <= w_timer_nxt;
      r_retry    <= w_retry_nxt;
      r_err_code <= w_err_code_nxt;
      if (w_accept) begin
        r_type <= req_type;
        r_arg0 <= f_lower(req_type);
        r_arg1 <= req_a1;
        r_arg2 <= req_a2;
        r_arg3 <= req_a3;
        r_arg4 <= req_a4;
      end
      if (w_to_issue) begin
        r_arg0 <= f_lower(r_type) - 8'h20;  // uppercase opcode
      end
    end
  end

  assign arg0     = r_arg0;
  assign arg1     = r_arg1;
  assign arg2     = r_arg2;
  assign arg3     = r_arg3;
  assign arg4     = r_arg4;
  assign err_code = r_err_code;

`ifdef NVMAIN_CMD_TRACE_EN
  always_ff @(posedge clk) begin
    if (command_enable)
      $display("[+](cmd_issuer) SEND: [ %h, %0d, %0d, %0d, %h ]", arg0, arg1, arg2, arg3, arg4);
    if (err)
      $display("[+](cmd_issuer) ERR: err_code=%0d req_type=%0d", err_code, r_type);
  end
`else
  // Trace disabled: no simulation output.
`endif

endmodule

// File: tb/tb_nvmain_cmd_issuer.sv
module tb_nvmain_cmd_issuer;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready;
  logic [1:0]  req_type;
  logic [31:0] req_a1, req_a2, req_a3;
  logic [7:0]  req_a4;
  logic        command_enable;
  logic [7:0]  arg0, arg4;
  logic [31:0] arg1, arg2, arg3;
  logic        rsp_valid, rsp_issuable;
  logic        done, err;
  logic [1:0]  err_code;

  always #5 clk = ~clk;

  nvmain_cmd_issuer #(.RETRY_GAP(4), .MAX_RETRY(3), .RSP_TIMEOUT(16)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_type(req_type),
    .req_a1(req_a1), .req_a2(req_a2), .req_a3(req_a3), .req_a4(req_a4),
    .command_enable(command_enable),
    .arg0(arg0), .arg1(arg1), .arg2(arg2), .arg3(arg3), .arg4(arg4),
    .rsp_valid(rsp_valid), .rsp_issuable(rsp_issuable),
    .done(done), .err(err), .err_code(err_code)
  );

  localparam logic [1:0] K_CMD = 2'd0, K_DONE = 2'd1, K_ERR = 2'd2;

  typedef struct packed {
    logic [1:0]  kind;
    logic [7:0]  a0;
    logic [31:0] a1;
    logic [31:0] a2;
    logic [31:0] a3;
    logic [7:0]  a4;
    logic [1:0]  code;
  } ev_t;

  ev_t sb[$];
  int  n_cmp = 0;
  int  n_mis = 0;
  int  cyc = 0;
  bit  obs_ce, obs_done, obs_err, prev_ce;
  int  acc_cyc, rsp_cyc;

  task automatic push_cmd(input logic [7:0] op, input logic [31:0] a1, input logic [31:0] a2,
                          input logic [31:0] a3, input logic [7:0] a4);
    ev_t e;
    e = '0; e.kind = K_CMD; e.a0 = op; e.a1 = a1; e.a2 = a2; e.a3 = a3; e.a4 = a4;
    sb.push_back(e);
  endtask

  task automatic push_end(input logic [1:0] kind, input logic [1:0] code);
    ev_t e;
    e = '0; e.kind = kind; e.code = code;
    sb.push_back(e);
  endtask

  // Advance one cycle, sample mid-cycle, match any strobe against the scoreboard.
  task automatic tick();
    ev_t o, e;
    @(posedge clk);
    @(negedge clk);
    cyc++;
    obs_ce = command_enable; obs_done = done; obs_err = err;
    if (obs_ce) begin
      n_cmp++;
      if (prev_ce) begin
        n_mis++;
        $display("FAIL ce_adjacent: command_enable high on cycles %0d and %0d, want separated", cyc - 1, cyc);
      end
    end
    prev_ce = obs_ce;
    if (obs_ce || obs_done || obs_err) begin
      o = '0;
      if (obs_ce) begin
        o.kind = K_CMD; o.a0 = arg0; o.a1 = arg1; o.a2 = arg2; o.a3 = arg3; o.a4 = arg4;
      end else if (obs_done) begin
        o.kind = K_DONE;
      end else begin
        o.kind = K_ERR; o.code = err_code;
      end
      n_cmp++;
      if (sb.size() == 0) begin
        n_mis++;
        $display("FAIL sb_unexpected: cycle %0d got event %h, want no event", cyc, o);
      end else begin
        e = sb.pop_front();
        if (o !== e) begin
          n_mis++;
          $display("FAIL sb_event: cycle %0d got %h, want %h", cyc, o, e);
        end
      end
    end
  endtask

  task automatic wait_ce(input string nm);
    int n;
    n = 0;
    while (!obs_ce && n < 40) begin tick(); n++; end
    if (!obs_ce) begin
      n_cmp++; n_mis++;
      $display("FAIL %s: no command strobe within 40 cycles, want one", nm);
    end
  endtask

  task automatic offer(input logic [1:0] t, input logic [31:0] a1, input logic [31:0] a2,
                       input logic [31:0] a3, input logic [7:0] a4, input bit keep);
    int n;
    n = 0;
    while (!req_ready && n < 40) begin tick(); n++; end
    n_cmp++;
    if (req_ready !== 1'b1) begin
      n_mis++;
      $display("FAIL offer_ready: req_ready=%b, want 1", req_ready);
    end
    req_valid = 1'b1; req_type = t; req_a1 = a1; req_a2 = a2; req_a3 = a3; req_a4 = a4;
    acc_cyc = cyc;
    tick();
    if (!keep) req_valid = 1'b0;
  endtask

  // Present a verdict d cycles after the current (query) cycle.
  task automatic answer(input int d, input bit iss);
    for (int i = 0; i < d; i++) tick();
    rsp_valid = 1'b1; rsp_issuable = iss; rsp_cyc = cyc;
    tick();
    rsp_valid = 1'b0; rsp_issuable = 1'b0;
  endtask

  task automatic check_sb_empty(input string nm);
    n_cmp++;
    if (sb.size() != 0) begin
      n_mis++;
      $display("FAIL %s: %0d expected events outstanding, want 0", nm, sb.size());
    end
  endtask

  task automatic check_reset_values(input string nm);
    logic [117:0] got, want;
    got  = {req_ready, command_enable, done, err, err_code, arg0, arg1, arg2, arg3, arg4};
    want = {1'b1, 117'd0};
    n_cmp++;
    if (got !== want) begin
      n_mis++;
      $display("FAIL %s: got %h, want %h", nm, got, want);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; req_valid = 1'b0; req_type = 2'd0; req_a1 = '0; req_a2 = '0; req_a3 = '0;
    req_a4 = '0; rsp_valid = 1'b0; rsp_issuable = 1'b0;
    #1;
    check_reset_values("reset_values");
    tick(); tick();
    check_reset_values("reset_held");
    reset = 1'b0;
  endtask

  task automatic test_read_immediate();
    int q;
    push_cmd(8'h72, 32'h1000, 32'd5, 32'd0, 8'h01);
    push_cmd(8'h52, 32'h1000, 32'd5, 32'd0, 8'h01);
    push_end(K_DONE, 2'd0);
    offer(2'd0, 32'h1000, 32'd5, 32'd0, 8'h01, 1'b0);
    q = cyc;
    n_cmp++;
    if (!obs_ce || q != acc_cyc + 1) begin
      n_mis++;
      $display("FAIL read_query_lat: ce=%0b at +%0d, want ce=1 at +1", obs_ce, q - acc_cyc);
    end
    answer(2, 1'b1);
    n_cmp++;
    if (!obs_ce || cyc != rsp_cyc + 1) begin
      n_mis++;
      $display("FAIL read_issue_lat: ce=%0b at +%0d after rsp, want ce=1 at +1", obs_ce, cyc - rsp_cyc);
    end
    tick();
    n_cmp++;
    if (!obs_done || cyc - acc_cyc != 5) begin
      n_mis++;
      $display("FAIL read_done_lat: done=%0b at +%0d, want done=1 at +5", obs_done, cyc - acc_cyc);
    end
    check_sb_empty("read_sb");
  endtask

  task automatic test_write_retry();
    int q[3];
    for (int i = 0; i < 3; i++) push_cmd(8'h77, 32'h2000, 32'd7, 32'd9, 8'h22);
    push_cmd(8'h57, 32'h2000, 32'd7, 32'd9, 8'h22);
    push_end(K_DONE, 2'd0);
    offer(2'd1, 32'h2000, 32'd7, 32'd9, 8'h22, 1'b0);
    for (int i = 0; i < 3; i++) begin
      wait_ce("write_query");
      q[i] = cyc;
      answer(2, i == 2);
    end
    n_cmp++;
    if (q[1] - q[0] != 7 || q[2] - q[1] != 7) begin
      n_mis++;
      $display("FAIL write_spacing: query gaps %0d,%0d, want 7,7", q[1] - q[0], q[2] - q[1]);
    end
    tick();
    n_cmp++;
    if (!obs_done) begin
      n_mis++;
      $display("FAIL write_done: done=%0b, want 1", obs_done);
    end
    check_sb_empty("write_sb");
  endtask

  task automatic test_retry_limit();
    for (int i = 0; i < 3; i++) push_cmd(8'h63, 32'h3000, 32'd1, 32'd2, 8'h33);
    push_end(K_ERR, 2'd1);
    offer(2'd3, 32'h3000, 32'd1, 32'd2, 8'h33, 1'b0);
    for (int i = 0; i < 3; i++) begin
      wait_ce("limit_query");
      rsp_valid = 1'b0; rsp_issuable = 1'b0;
      answer(1, 1'b0);
      // An issuable verdict during backoff must be ignored.
      if (i < 2) begin rsp_valid = 1'b1; rsp_issuable = 1'b1; end
    end
    n_cmp++;
    if (!obs_err || err_code !== 2'd1 || cyc != rsp_cyc + 1) begin
      n_mis++;
      $display("FAIL limit_err: err=%0b code=%0d at +%0d, want err=1 code=1 at +1", obs_err, err_code, cyc - rsp_cyc);
    end
    tick();
    n_cmp++;
    if (req_ready !== 1'b1 || err_code !== 2'd1) begin
      n_mis++;
      $display("FAIL limit_after: req_ready=%b err_code=%0d, want 1 and 1", req_ready, err_code);
    end
    check_sb_empty("limit_sb");
  endtask

  task automatic test_timeout();
    int q, n;
    push_cmd(8'h6C, 32'h4000, 32'd3, 32'd4, 8'h44);
    push_end(K_ERR, 2'd2);
    offer(2'd2, 32'h4000, 32'd3, 32'd4, 8'h44, 1'b0);
    q = cyc;
    n = 0;
    while (!obs_err && n < 40) begin tick(); n++; end
    n_cmp++;
    if (!obs_err || cyc - (q + 1) != 16 || err_code !== 2'd2) begin
      n_mis++;
      $display("FAIL timeout_err: err=%0b code=%0d at +%0d from wait entry, want err=1 code=2 at +16",
               obs_err, err_code, cyc - (q + 1));
    end
    check_sb_empty("timeout_sb");
    // Verdict arriving on the last timeout cycle wins.
    push_cmd(8'h6C, 32'h4001, 32'd8, 32'd9, 8'h45);
    push_cmd(8'h4C, 32'h4001, 32'd8, 32'd9, 8'h45);
    push_end(K_DONE, 2'd0);
    offer(2'd2, 32'h4001, 32'd8, 32'd9, 8'h45, 1'b0);
    q = cyc;
    answer(16, 1'b1);
    n_cmp++;
    if (!obs_ce || obs_err) begin
      n_mis++;
      $display("FAIL timeout_race: ce=%0b err=%0b, want ce=1 err=0", obs_ce, obs_err);
    end
    tick();
    n_cmp++;
    if (!obs_done) begin
      n_mis++;
      $display("FAIL timeout_race_done: done=%0b, want 1", obs_done);
    end
    check_sb_empty("timeout_race_sb");
  endtask

  task automatic test_reset_backoff();
    push_cmd(8'h72, 32'h5000, 32'd1, 32'd1, 8'h55);
    offer(2'd0, 32'h5000, 32'd1, 32'd1, 8'h55, 1'b0);
    answer(1, 1'b0);
    tick();
    #2 reset = 1'b1;
    #1;
    check_reset_values("reset_async");
    tick(); tick();
    n_cmp++;
    if (obs_done || obs_err) begin
      n_mis++;
      $display("FAIL reset_no_pulse: done=%0b err=%0b, want 0 0", obs_done, obs_err);
    end
    reset = 1'b0;
    check_sb_empty("reset_sb");
    push_cmd(8'h77, 32'h5100, 32'd2, 32'd3, 8'h56);
    push_cmd(8'h57, 32'h5100, 32'd2, 32'd3, 8'h56);
    push_end(K_DONE, 2'd0);
    offer(2'd1, 32'h5100, 32'd2, 32'd3, 8'h56, 1'b0);
    answer(1, 1'b1);
    tick();
    n_cmp++;
    if (!obs_done) begin
      n_mis++;
      $display("FAIL reset_recover: done=%0b, want 1", obs_done);
    end
    check_sb_empty("reset_recover_sb");
  endtask

  task automatic test_back_to_back();
    int d;
    push_cmd(8'h72, 32'h6000, 32'd1, 32'd2, 8'h61);
    push_cmd(8'h52, 32'h6000, 32'd1, 32'd2, 8'h61);
    push_end(K_DONE, 2'd0);
    push_cmd(8'h63, 32'h7000, 32'd3, 32'd4, 8'h71);
    push_cmd(8'h43, 32'h7000, 32'd3, 32'd4, 8'h71);
    push_end(K_DONE, 2'd0);
    offer(2'd0, 32'h6000, 32'd1, 32'd2, 8'h61, 1'b1);
    req_type = 2'd3; req_a1 = 32'h7000; req_a2 = 32'd3; req_a3 = 32'd4; req_a4 = 8'h71;
    answer(1, 1'b1);
    tick();
    d = cyc;
    n_cmp++;
    if (!obs_done || req_ready !== 1'b0) begin
      n_mis++;
      $display("FAIL b2b_done: done=%0b req_ready=%b, want 1 0", obs_done, req_ready);
    end
    tick();
    n_cmp++;
    if (req_ready !== 1'b1) begin
      n_mis++;
      $display("FAIL b2b_idle: req_ready=%b, want 1", req_ready);
    end
    tick();
    req_valid = 1'b0;
    n_cmp++;
    if (!obs_ce || cyc != d + 2) begin
      n_mis++;
      $display("FAIL b2b_second_query: ce=%0b at +%0d after done, want ce=1 at +2", obs_ce, cyc - d);
    end
    answer(1, 1'b1);
    tick();
    n_cmp++;
    if (!obs_done) begin
      n_mis++;
      $display("FAIL b2b_second_done: done=%0b, want 1", obs_done);
    end
    check_sb_empty("b2b_sb");
  endtask

  initial begin
    test_reset();
    test_read_immediate();
    test_write_retry();
    test_retry_limit();
    test_timeout();
    test_reset_backoff();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/nvmain_cmd_issuer.md
Name: nvmain_cmd_issuer

Overview:
- Initiator side of the NVMain command interface; drives the one-cycle command strobe plus 5-field argument bus consumed by the VPI NVMain test harness.
- Accepts one memory request at a time from a requester over valid/ready.
- Sends the lowercase "is_issuable" query, waits for the harness verdict, then sends the uppercase "issue" command; retries or reports errors as needed.

Parameters:
- RETRY_GAP, 4, idle cycles between a rejected query and the next query (1..255).
- MAX_RETRY, 8, rejected queries tolerated before error (1..255).
- RSP_TIMEOUT, 16, cycles allowed in WAIT_RSP without rsp_valid before error (1..65535).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- req_valid  in  1  request offered
- req_ready  out  1  issuer idle, request accepted when valid&ready
- req_type  in  2  0=read('r'/'R' 0x72/0x52), 1=write('w'/'W' 0x77/0x57), 2='l'/'L' (0x6C/0x4C), 3='c'/'C' (0x63/0x43)
- req_a1  in  32  argument 1 (address)
- req_a2  in  32  argument 2
- req_a3  in  32  argument 3
- req_a4  in  8  argument 4 (flags/tag)
- command_enable  out  1  one-cycle command strobe to harness
- arg0  out  8  ASCII opcode
- arg1, arg2, arg3  out  32 each  arguments
- arg4  out  8  argument
- rsp_valid  in  1  harness verdict strobe for the outstanding query
- rsp_issuable  in  1  verdict: 1 = issuable
- done  out  1  one-cycle pulse: uppercase command sent
- err  out  1  one-cycle pulse: request abandoned
- err_code  out  2  valid with err: 1=retry limit, 2=timeout; holds last value

Behaviour:
- Reset (async): state IDLE; req_ready=1; command_enable=0; arg0..arg4=0; done=0; err=0; err_code=0; retry and timer counters 0.
- Request fields latched into an internal buffer on the accept edge; arg1..arg4 driven from the buffer throughout the request; arg0 and arg1..arg4 change only on the cycle command_enable rises.
- States:
  - IDLE: req_ready=1. On valid&ready, latch the request and go to QUERY. req_ready=0 in every other state.
  - QUERY: for exactly one cycle, command_enable=1 and arg0=lowercase opcode. Next state WAIT_RSP; timer cleared.
  - WAIT_RSP: command_enable=0; timer increments each cycle.
    - rsp_valid&rsp_issuable -> ISSUE.
    - rsp_valid&!rsp_issuable -> retry+1; if retry+1==MAX_RETRY go to ERR(code 1), else go to BACKOFF.
    - No rsp_valid and timer reaches RSP_TIMEOUT-1 -> ERR(code 2).
    - If rsp_valid arrives on the timeout cycle, the response wins.
  - BACKOFF: count RETRY_GAP cycles, then QUERY. rsp_valid is ignored.
  - ISSUE: for one cycle, command_enable=1, arg0=lowercase-0x20, same arg1..arg4. Next state DONE.
  - DONE: done=1 for one cycle; retry cleared; go to IDLE.
  - ERR: err=1 and err_code set for one cycle; retry cleared; go to IDLE.
- Latencies:
  - Accept to query strobe: 1 cycle.
  - Issuable verdict to issue strobe: 1 cycle.
  - Issue strobe to done: 1 cycle.
  - A request can be accepted on the cycle after done/err (IDLE).
- command_enable is never high on two consecutive cycles (one command per cycle, separated).
- rsp_valid in any state other than WAIT_RSP is ignored.
- req_type is fully decoded; no illegal opcode is ever generated.
- Reset asserted mid-request drops the request silently (no done/err) and returns to IDLE values immediately.

Optional Feature:
- Macro: NVMAIN_CMD_TRACE_EN.
- Defined: on every command_enable cycle, simulation prints "[+](cmd_issuer) SEND: [ op, a1, a2, a3, a4 ]" (op and a4 in hex, a1..a3 in decimal). Also prints one line per err, giving err_code and req_type.
- Undefined: no display statements; logic identical.

Test Plan:
- Read, immediate accept: req_type=0, a1=0x1000, a2=5, a3=0, a4=0x01; harness rsp_valid&issuable 2 cycles after query. Expected: arg0=0x72 strobe, then arg0=0x52 strobe 1 cycle after rsp, done 1 cycle later, 5 cycles accept-to-done.
- Write, two rejections: type=1, RETRY_GAP=4, two not-issuable verdicts then issuable. Expected: three 0x77 strobes spaced by response delay+4+1, one 0x57 strobe, done, no err.
- Retry limit: MAX_RETRY=3, always not-issuable, type=3. Expected: exactly three 0x63 strobes, no 0x43, err=1 with err_code=1, req_ready=1 next cycle.
- Timeout: type=2, no rsp_valid, RSP_TIMEOUT=16. Expected: one 0x6C strobe, err with err_code=2 exactly 16 cycles after WAIT_RSP entry; rsp_valid on that same cycle instead yields 0x4C issue.
- Reset mid-BACKOFF: assert reset asynchronously. Expected: outputs return to reset values without a clock edge, no done/err pulse, and a new request is accepted after reset release.
- Back-to-back requests with req_valid held high: second request accepted only in the IDLE cycle after done; command_enable never high on adjacent cycles.
